friscv_mem_arbiter: RTL

- Two-requester arbiter sharing one data memory port, using the same en/wr/addr/wdata/strb/rdata/ready protocol the load/store unit drives.
- Requester 0 is the instruction fetch path and requester 1 is the load/store unit; the single output port connects to the shared RAM.
- Grants are locked for the whole transaction, including two-phase unaligned accesses, and released only when the granted requester deasserts en.

---
 rtl/friscv_mem_arbiter_pkg.sv | 10 +
 rtl/friscv_mem_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/friscv_mem_arbiter_pkg.sv
// Shared definitions for the two-requester data memory arbiter.
package friscv_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/friscv_mem_arbiter.sv
// Two-requester arbiter (fetch / load-store) in front of one shared RAM port.
// A grant is held for the whole transaction and released when its en drops.
module friscv_mem_arbiter
    import friscv_mem_arbiter_pkg::*;
#(
    parameter int ADDRW = 16,
    parameter int XLEN  = 32,
    parameter int RR_EN = 1
)(
    input  logic               aclk,
    input  logic               srst,
    input  logic               rq0_en,
    input  logic               rq0_wr,
    input  logic [ADDRW-1:0]   rq0_addr,
    input  logic [XLEN-1:0]    rq0_wdata,
    input  logic [XLEN/8-1:0]  rq0_strb,
    output logic [XLEN-1:0]    rq0_rdata,
    output logic               rq0_ready,
    input  logic               rq1_en,
    input  logic               rq1_wr,
    input  logic [ADDRW-1:0]   rq1_addr,
    input  logic [XLEN-1:0]    rq1_wdata,
    input  logic [XLEN/8-1:0]  rq1_strb,
    output logic [XLEN-1:0]    rq1_rdata,
    output logic               rq1_ready,
    output logic               mem_en,
    output logic               mem_wr,
    output logic [ADDRW-1:0]   mem_addr,
    output logic [XLEN-1:0]    mem_wdata,
    output logic [XLEN/8-1:0]  mem_strb,
    input  logic [XLEN-1:0]    mem_rdata,
    input  logic               mem_ready
);

    arb_state_t state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic [1:0] req;
    logic [1:0] gnt_sel;

    // Generic 2-way round-robin: on contention favour the one not served last.
    function automatic logic [1:0] rr_grant(input logic [1:0] r, input logic last);
        logic [1:0] g;
        if (r == 2'b11) begin
            g = last ? 2'b01 : 2'b10;
        end else begin
            g = r;
        end
        return g;
    endfunction

    assign req = {rq1_en, rq0_en};

    always_ff @(posedge aclk) begin
        if (srst) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_sel      = 2'b00;
        case (state_q)
            ARB_IDLE: begin
                if (RR_EN != 0) begin
                    gnt_sel = rr_grant(req, last_grant_q);
                end else begin
                    gnt_sel = req[1] ? 2'b10 : req;
                end
                if (gnt_sel[1]) begin
                    state_d = ARB_GNT1;
                end else if (gnt_sel[0]) begin
                    state_d = ARB_GNT0;
                end
            end
            ARB_GNT0: begin
                if (!rq0_en) begin
                    state_d = rq1_en ? ARB_GNT1 : ARB_IDLE;
                end
            end
            ARB_GNT1: begin
                if (!rq1_en) begin
                    state_d = rq0_en ? ARB_GNT0 : ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        if (state_d == ARB_GNT0 && state_q != ARB_GNT0) begin
            last_grant_d = 1'b0;
        end else if (state_d == ARB_GNT1 && state_q != ARB_GNT1) begin
            last_grant_d = 1'b1;
        end
    end

    assign rq0_rdata = mem_rdata;
    assign rq1_rdata = mem_rdata;

    // Request fields pass straight through so address steps between phases reach the RAM.
    always_comb begin
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_strb  = '0;
        rq0_ready = 1'b0;
        rq1_ready = 1'b0;
        case (state_q)
            ARB_GNT0: begin
                mem_en    = rq0_en;
                mem_wr    = rq0_wr;
                mem_addr  = rq0_addr;
                mem_wdata = rq0_wdata;
                mem_strb  = rq0_strb;
                rq0_ready = mem_ready;
            end
            ARB_GNT1: begin
                mem_en    = rq1_en;
                mem_wr    = rq1_wr;
                mem_addr  = rq1_addr;
                mem_wdata = rq1_wdata;
                mem_strb  = rq1_strb;
                rq1_ready = mem_ready;
            end
            default: ;
        endcase
    end

endmodule
